c7bintc: RTL and testbench

- External hardware-interrupt front end that sits directly upstream of the CSR block.
- Takes up to 8 asynchronous interrupt pins and synchronizes them into the core clock domain, then debounces them.
- Per line, latches each interrupt as edge- or level-triggered and applies a mask.
- Drives the HWI0..7 status vector and the single ext_intr_sync request into the CSR block. Also provides a highest-priority interrupt ID with an acknowledge handshake, used by the exception-control logic.

---
 rtl/c7bintc_pkg.sv | 29 ++
 rtl/c7bintc_filt.sv | 98 +++++++++
 rtl/c7bintc.sv | 97 +++++++++
 tb/tb_c7bintc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7bintc_pkg.sv
// ============================================================================
// Module  : c7bintc_pkg
// Brief   : Shared widths, parameter defaults and priority helper for c7bintc.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package c7bintc_pkg;

    localparam int INTC_ID_W            = 3;
    localparam int INTC_MAX_IRQ         = 8;
    localparam int INTC_SYNC_STAGES_DEF = 2;
    localparam int INTC_DEBOUNCE_DEF    = 3;

    // Fixed priority: the lowest set index wins, 0 when nothing is set.
    function automatic logic [INTC_ID_W-1:0] prio_id(input logic [INTC_MAX_IRQ-1:0] vec);
        logic [INTC_ID_W-1:0] id;
        id = '0;
        for (int i = INTC_MAX_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = INTC_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

`default_nettype wire

// File: rtl/c7bintc_filt.sv
// ============================================================================
// Module  : c7bintc_filt
// Brief   : One interrupt line: synchronizer chain, debounce filter, delayed level.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module c7bintc_filt
    import c7bintc_pkg::*;
#(
    parameter int SYNC_STAGES = INTC_SYNC_STAGES_DEF,
    parameter int DEBOUNCE    = INTC_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic filt,
    output logic filt_d
);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   w_sync;
    logic                   w_filt;
    logic                   r_filt_d_q;
    logic                   w_filt_d_d;

    always_comb begin
        w_sync_d = {r_sync_q[SYNC_STAGES-2:0], irq_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q <= '0;
        end else begin
            r_sync_q <= w_sync_d;
        end
    end

    assign w_sync = r_sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign w_filt = w_sync;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE + 1);

            logic [CNT_W-1:0] r_cnt_q;
            logic [CNT_W-1:0] w_cnt_d;
            logic             r_filt_q;
            logic             w_filt_d;

            // The DEBOUNCE-th consecutive differing sample flips the level instead
            // of bumping the counter, so a shorter glitch can never get through.
            always_comb begin
                w_cnt_d  = '0;
                w_filt_d = r_filt_q;
                if (w_sync != r_filt_q) begin
                    if (r_cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                        w_filt_d = w_sync;
                    end else begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt_q  <= '0;
                    r_filt_q <= 1'b0;
                end else begin
                    r_cnt_q  <= w_cnt_d;
                    r_filt_q <= w_filt_d;
                end
            end

            assign w_filt = r_filt_q;
        end
    endgenerate

    always_comb begin
        w_filt_d_d = w_filt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_d_q <= 1'b0;
        end else begin
            r_filt_d_q <= w_filt_d_d;
        end
    end

    assign filt   = w_filt;
    assign filt_d = r_filt_d_q;

endmodule

`default_nettype wire

// File: rtl/c7bintc.sv
// ============================================================================
// Module  : c7bintc
// Brief   : External interrupt front end: per-line filter, edge/level pending,
//           masking, fixed-priority ID with acknowledge, HWI vector to the CSRs.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module c7bintc
    import c7bintc_pkg::*;
#(
    parameter int NUM_IRQ     = INTC_MAX_IRQ,
    parameter int SYNC_STAGES = INTC_SYNC_STAGES_DEF,
    parameter int DEBOUNCE    = INTC_DEBOUNCE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic [NUM_IRQ-1:0]   cfg_edge,
    input  logic [NUM_IRQ-1:0]   cfg_mask,
    input  logic [NUM_IRQ-1:0]   pend_clr,
    input  logic                 ecl_intc_ack,
    output logic [NUM_IRQ-1:0]   intc_pending,
    output logic [NUM_IRQ-1:0]   intc_csr_hwi,
    output logic                 intc_csr_ext_intr_sync,
    output logic                 intc_irq_valid,
    output logic [INTC_ID_W-1:0] intc_irq_id
);

    logic [NUM_IRQ-1:0]      w_filt;
    logic [NUM_IRQ-1:0]      w_filt_dly;
    logic [NUM_IRQ-1:0]      w_rise;
    logic [NUM_IRQ-1:0]      w_clr;
    logic [NUM_IRQ-1:0]      w_hwi;
    logic [INTC_MAX_IRQ-1:0] w_hwi_ext;
    logic                    w_valid;
    logic [INTC_ID_W-1:0]    w_id;
    logic [NUM_IRQ-1:0]      r_pend_q;
    logic [NUM_IRQ-1:0]      w_pend_d;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
            c7bintc_filt #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE    (DEBOUNCE)
            ) u_filt (
                .clk    (clk),
                .rst    (rst),
                .irq_in (irq_in[gi]),
                .filt   (w_filt[gi]),
                .filt_d (w_filt_dly[gi])
            );
        end
    endgenerate

    assign w_rise = w_filt & ~w_filt_dly;
    assign w_hwi  = r_pend_q & cfg_mask;

    always_comb begin
        w_hwi_ext              = '0;
        w_hwi_ext[NUM_IRQ-1:0] = w_hwi;
    end

    assign w_valid = |w_hwi;
    assign w_id    = prio_id(w_hwi_ext);

    // Level lines ignore clears entirely; on edge lines a fresh rise beats a clear.
    always_comb begin
        w_clr    = '0;
        w_pend_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_clr[i] = pend_clr[i] | (ecl_intc_ack & w_valid & (w_id == INTC_ID_W'(i)));
            if (cfg_edge[i]) begin
                w_pend_d[i] = w_rise[i] | (r_pend_q[i] & ~w_clr[i]);
            end else begin
                w_pend_d[i] = w_filt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_q <= '0;
        end else begin
            r_pend_q <= w_pend_d;
        end
    end

    assign intc_pending           = r_pend_q;
    assign intc_csr_hwi           = w_hwi;
    assign intc_csr_ext_intr_sync = w_valid;
    assign intc_irq_valid         = w_valid;
    assign intc_irq_id            = w_id;

endmodule

`default_nettype wire

// File: tb/tb_c7bintc.sv
// ============================================================================
// Module  : tb_c7bintc
// Brief   : Self-checking bench for c7bintc: directed sequences, a vector table
//           and randomized traffic against a behavioural model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_c7bintc;

    localparam int N = 8;
    localparam int S = 2;
    localparam int D = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_in;
    logic [N-1:0] cfg_edge;
    logic [N-1:0] cfg_mask;
    logic [N-1:0] pend_clr;
    logic         ecl_intc_ack;
    logic [N-1:0] intc_pending;
    logic [N-1:0] intc_csr_hwi;
    logic         intc_csr_ext_intr_sync;
    logic         intc_irq_valid;
    logic [2:0]   intc_irq_id;

    int checks = 0;
    int errors = 0;

    c7bintc #(
        .NUM_IRQ     (N),
        .SYNC_STAGES (S),
        .DEBOUNCE    (D)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .irq_in                 (irq_in),
        .cfg_edge               (cfg_edge),
        .cfg_mask               (cfg_mask),
        .pend_clr               (pend_clr),
        .ecl_intc_ack           (ecl_intc_ack),
        .intc_pending           (intc_pending),
        .intc_csr_hwi           (intc_csr_hwi),
        .intc_csr_ext_intr_sync (intc_csr_ext_intr_sync),
        .intc_irq_valid         (intc_irq_valid),
        .intc_irq_id            (intc_irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: pin delayed S cycles, level flips once the last D
    // synchronized samples all disagree with it, pending follows the mode rules.
    bit m_sh   [N][S];
    bit m_hist [N][D];
    bit m_filt [N];
    bit m_filtd[N];
    bit m_pend [N];

    function automatic logic [N-1:0] m_pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [20:0] model_out();
        logic [N-1:0] p, h;
        logic [2:0]   id;
        p  = m_pend_vec();
        h  = p & cfg_mask;
        id = 3'd0;
        for (int i = N - 1; i >= 0; i--) if (h[i]) id = 3'(i);
        return {p, h, |h, |h, id};
    endfunction

    function automatic logic [20:0] dut_out();
        return {intc_pending, intc_csr_hwi, intc_csr_ext_intr_sync, intc_irq_valid, intc_irq_id};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < S; k++) m_sh[i][k] = 1'b0;
            for (int k = 0; k < D; k++) m_hist[i][k] = 1'b0;
            m_filt[i] = 1'b0; m_filtd[i] = 1'b0; m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [20:0] o;
        bit so, all_diff, nfilt, rise, clr;
        o = model_out();
        for (int i = 0; i < N; i++) begin
            so = m_sh[i][S-1];
            for (int k = D - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
            m_hist[i][0] = so;
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) if (m_hist[i][k] == m_filt[i]) all_diff = 1'b0;
            nfilt = all_diff ? so : m_filt[i];
            rise  = m_filt[i] & ~m_filtd[i];
            clr   = pend_clr[i] | (ecl_intc_ack & o[3] & (o[2:0] == 3'(i)));
            m_pend[i]  = cfg_edge[i] ? (rise | (m_pend[i] & ~clr)) : m_filt[i];
            m_filtd[i] = m_filt[i];
            m_filt[i]  = nfilt;
            for (int k = S - 1; k > 0; k--) m_sh[i][k] = m_sh[i][k-1];
            m_sh[i][0] = irq_in[i];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the current inputs, then sample the DUT.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic [N-1:0] mask;
        logic [N-1:0] hwi;
        logic [2:0]   id;
    } vec_t;

    vec_t tbl [0:5];

    initial begin
        tbl[0] = '{irq: 8'h81, mask: 8'hFF, hwi: 8'h81, id: 3'd0};
        tbl[1] = '{irq: 8'hF0, mask: 8'h30, hwi: 8'h30, id: 3'd4};
        tbl[2] = '{irq: 8'h0A, mask: 8'h08, hwi: 8'h08, id: 3'd3};
        tbl[3] = '{irq: 8'h00, mask: 8'hFF, hwi: 8'h00, id: 3'd0};
        tbl[4] = '{irq: 8'hC0, mask: 8'h80, hwi: 8'h80, id: 3'd7};
        tbl[5] = '{irq: 8'h66, mask: 8'h99, hwi: 8'h00, id: 3'd0};

        rst = 1'b1; irq_in = 8'hFF; cfg_edge = '0; cfg_mask = 8'hFF;
        pend_clr = '0; ecl_intc_ack = 1'b0;
        model_reset();

        // Reset holds everything at zero even with every pin high.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_outputs", 32'(dut_out()), 32'h0);
        end
        irq_in = '0;
        rst    = 1'b0;
        step();
        check("post_reset_first", 32'(dut_out()), 32'h0);
        steps(3);
        check("idle_after_reset", 32'(dut_out()), 32'h0);

        // Level latency: pin changes just after edge 0, result appears after edge 6.
        cfg_mask = 8'h01;
        irq_in   = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 6) check("lvl_rise_early", 32'(intc_csr_hwi), 32'h0);
        end
        check("lvl_rise_hwi", 32'(intc_csr_hwi), 32'h01);
        check("lvl_rise_sync", 32'(intc_csr_ext_intr_sync), 32'h1);
        check("lvl_rise_id", 32'(intc_irq_id), 32'h0);
        irq_in = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 6) check("lvl_fall_early", 32'(intc_csr_hwi), 32'h01);
        end
        check("lvl_fall_hwi", 32'(intc_csr_hwi), 32'h0);
        check("lvl_fall_sync", 32'(intc_csr_ext_intr_sync), 32'h0);

        // Glitch rejection, then a 3-cycle pulse that an edge line latches.
        irq_in = 8'h04; steps(2);
        irq_in = 8'h00; steps(8);
        check("glitch_pending", 32'(intc_pending), 32'h0);
        cfg_edge = 8'h04;
        irq_in = 8'h04; steps(3);
        irq_in = 8'h00; steps(8);
        check("pulse_latched", 32'(intc_pending), 32'h04);
        pend_clr = 8'h04; step(); pend_clr = 8'h00;
        check("pend_clr", 32'(intc_pending), 32'h0);

        // Priority and acknowledge with edge lines 5 and 3.
        cfg_edge = 8'hFF; cfg_mask = 8'hFF;
        irq_in = 8'h28; steps(4);
        irq_in = 8'h00; steps(8);
        check("prio_pending", 32'(intc_pending), 32'h28);
        check("prio_id3", 32'(intc_irq_id), 32'h3);
        ecl_intc_ack = 1'b1; step(); ecl_intc_ack = 1'b0;
        check("ack1_id5", 32'(intc_irq_id), 32'h5);
        check("ack1_pending", 32'(intc_pending), 32'h20);
        ecl_intc_ack = 1'b1; step(); ecl_intc_ack = 1'b0;
        check("ack2_valid", 32'(intc_irq_valid), 32'h0);
        check("ack2_id", 32'(intc_irq_id), 32'h0);

        // Acknowledge of a level line does not drop it.
        cfg_edge = 8'h00; cfg_mask = 8'h01;
        irq_in = 8'h01; steps(8);
        ecl_intc_ack = 1'b1; step(); ecl_intc_ack = 1'b0;
        check("ack_level", 32'(intc_pending), 32'h01);
        irq_in = 8'h00; steps(8);

        // Software clear colliding with a new rise on line 1.
        cfg_edge = 8'h02; cfg_mask = 8'h00;
        irq_in = 8'h02; steps(4);
        irq_in = 8'h00; steps(8);
        irq_in = 8'h02; steps(5);
        pend_clr = 8'h02; step(); pend_clr = 8'h00;
        check("set_beats_clr", 32'(intc_pending), 32'h02);
        ecl_intc_ack = 1'b1; step(); ecl_intc_ack = 1'b0;
        check("ack_no_valid", 32'(intc_pending), 32'h02);
        irq_in = 8'h00; steps(8);
        pend_clr = 8'h02; step(); pend_clr = 8'h00;
        check("clr_after", 32'(intc_pending), 32'h0);

        // A masked edge line stays pending and shows up the moment it is unmasked.
        cfg_edge = 8'h10; cfg_mask = 8'h00;
        irq_in = 8'h10; steps(4);
        irq_in = 8'h00; steps(8);
        check("masked_hwi", 32'(intc_csr_hwi), 32'h0);
        check("masked_pending", 32'(intc_pending), 32'h10);
        cfg_mask = 8'h10;
        #1;
        check("unmask_hwi", 32'(intc_csr_hwi), 32'h10);
        step();

        // Level-mode vector table.
        cfg_edge = 8'h00;
        for (int t = 0; t < 6; t++) begin
            irq_in   = tbl[t].irq;
            cfg_mask = tbl[t].mask;
            steps(7);
            check("tbl_hwi", 32'(intc_csr_hwi), 32'(tbl[t].hwi));
            check("tbl_id", 32'(intc_irq_id), 32'(tbl[t].id));
            check("tbl_sync", 32'(intc_csr_ext_intr_sync), 32'(tbl[t].hwi != 8'h00));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 2) irq_in[i] = ~irq_in[i];
            end
            if ($urandom_range(0, 49) == 0) cfg_edge = 8'($urandom);
            if ($urandom_range(0, 9) == 0) cfg_mask = 8'($urandom);
            pend_clr     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            ecl_intc_ack = ($urandom_range(0, 3) == 0);
            step();
        end

        // Asynchronous reset mid-activity discards everything at once.
        irq_in = 8'hFF; cfg_mask = 8'hFF; cfg_edge = 8'h0F;
        pend_clr = 8'h00; ecl_intc_ack = 1'b0;
        steps(4);
        #2 rst = 1'b1;
        #1;
        check("async_reset", 32'(dut_out()), 32'h0);
        model_reset();
        @(posedge clk); #1;
        irq_in = 8'h00;
        rst    = 1'b0;
        step();
        check("after_mid_reset", 32'(dut_out()), 32'h0);
        steps(8);
        check("quiet_after_reset", 32'(dut_out()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
